// File: rtl/hn_mem_node.sv
// Home-node memory target: accepts one request at a time, commits writes from the
// write-data channel or returns reads on the read-data channel, then issues a completion.
module hn_mem_node #(
  parameter int ADDR_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 1,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [OPCODE_WIDTH+ADDR_WIDTH-1:0]        req,
  input  logic                                      wdat_valid,
  output logic                                      wdat_ready,
  input  logic [OPCODE_WIDTH+ADDR_WIDTH+WORD_WIDTH-1:0] wdat,
  output logic                                      rdat_valid,
  input  logic                                      rdat_ready,
  output logic [OPCODE_WIDTH+ADDR_WIDTH+WORD_WIDTH-1:0] rdat,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [OPCODE_WIDTH-1:0]                   resp,
  output logic [7:0]                                wr_cnt,
  output logic [7:0]                                rd_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DW    = OPCODE_WIDTH + ADDR_WIDTH + WORD_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ      = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_DATA_RECV = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] RESP_OK      = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] RESP_NOK     = OPCODE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ASSERTED  = 2'd1,
    ST_DATA_PASS = 2'd2
  } state_t;

  state_t                  state, next_state;
  logic [OPCODE_WIDTH-1:0] lat_op;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [WORD_WIDTH-1:0]   mem [DEPTH];

  logic [OPCODE_WIDTH-1:0] req_op;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [OPCODE_WIDTH-1:0] wdat_op;
  logic [ADDR_WIDTH-1:0]   wdat_addr;
  logic [WORD_WIDTH-1:0]   wdat_data;
  logic                    req_hs, wdat_hs, rdat_hs, resp_hs, wdat_ok;

  assign req_op    = req[OPCODE_WIDTH+ADDR_WIDTH-1 -: OPCODE_WIDTH];
  assign req_addr  = req[ADDR_WIDTH-1:0];
  assign wdat_op   = wdat[DW-1 -: OPCODE_WIDTH];
  assign wdat_addr = wdat[ADDR_WIDTH+WORD_WIDTH-1 -: ADDR_WIDTH];
  assign wdat_data = wdat[WORD_WIDTH-1:0];

  assign req_hs  = req_valid  && req_ready;
  assign wdat_hs = wdat_valid && wdat_ready;
  assign rdat_hs = rdat_valid && rdat_ready;
  assign resp_hs = resp_valid && resp_ready;
  assign wdat_ok = (wdat_op == OP_DATA_RECV) && (wdat_addr == lat_addr);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Readies and valids depend on registered state only, never on input handshakes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_state = state;
    req_ready  = 1'b0;
    wdat_ready = 1'b0;
    rdat_valid = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_hs) next_state = ST_ASSERTED;
      end
      ST_ASSERTED: begin
        wdat_ready = (lat_op != OP_READ);
        rdat_valid = (lat_op == OP_READ);
        if (wdat_hs || rdat_hs) next_state = ST_DATA_PASS;
      end
      ST_DATA_PASS: begin
        resp_valid = 1'b1;
        if (resp_hs) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op   <= OP_WRITE;
      lat_addr <= '0;
      rdat     <= '0;
      resp     <= RESP_OK;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      if (req_hs) begin
        lat_op   <= req_op;
        lat_addr <= req_addr;
        if (req_op == OP_READ) rdat <= {OP_DATA_RECV, req_addr, mem[req_addr]};
      end
      if (wdat_hs) begin
        resp <= wdat_ok ? RESP_OK : RESP_NOK;
        if (wdat_ok) wr_cnt <= wr_cnt + 8'd1;
      end
      if (rdat_hs) begin
        resp   <= RESP_OK;
        rd_cnt <= rd_cnt + 8'd1;
      end
    end
  end

  // NOTE: the memory is reset on purpose: contents must read back as zero after any
  // reset, including one that interrupts a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wdat_hs && wdat_ok) begin
      mem[lat_addr] <= wdat_data;
    end
  end

endmodule

// File: tb/tb_hn_mem_node.sv
// Directed bench for hn_mem_node: exact-latency reads/writes, rejects, backpressure,
// asynchronous reset mid-write and write-counter wrap.
module tb_hn_mem_node;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req;
  logic        wdat_valid, wdat_ready;
  logic [11:0] wdat;
  logic        rdat_valid, rdat_ready;
  logic [11:0] rdat;
  logic        resp_valid, resp_ready;
  logic [0:0]  resp;
  logic [7:0]  wr_cnt, rd_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_wr = 8'd0;
  logic [7:0] exp_rd = 8'd0;

  always #5 clk = ~clk;

  hn_mem_node #(.ADDR_WIDTH(3), .OPCODE_WIDTH(1), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  32'(req_ready),  32'd1);
    check({tag, ".wdat_ready"}, 32'(wdat_ready), 32'd0);
    check({tag, ".rdat_valid"}, 32'(rdat_valid), 32'd0);
    check({tag, ".rdat"},       32'(rdat),       32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".resp"},       32'(resp),       32'd0);
    check({tag, ".wr_cnt"},     32'(wr_cnt),     32'd0);
    check({tag, ".rd_cnt"},     32'(rd_cnt),     32'd0);
  endtask

  // Read with optional stalls; zero stalls checks the 3-cycle minimum exactly.
  task automatic do_read(input logic [2:0] addr, input logic [7:0] exp_data,
                         input int rdat_stall, input int resp_stall);
    @(negedge clk);
    check("rd.req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req = {1'b1, addr};
    @(negedge clk);
    req_valid = 1'b0;
    check("rd.rdat_valid", 32'(rdat_valid), 32'd1);
    check("rd.rdat", 32'(rdat), 32'({1'b0, addr, exp_data}));
    for (int i = 0; i < rdat_stall; i++) begin
      @(negedge clk);
      check("rd.stall_rdat_valid", 32'(rdat_valid), 32'd1);
      check("rd.stall_rdat", 32'(rdat), 32'({1'b0, addr, exp_data}));
      check("rd.stall_req_ready", 32'(req_ready), 32'd0);
    end
    rdat_ready = 1'b1;
    @(negedge clk);
    rdat_ready = 1'b0;
    exp_rd = exp_rd + 8'd1;
    check("rd.resp_valid", 32'(resp_valid), 32'd1);
    check("rd.rdat_valid_low", 32'(rdat_valid), 32'd0);
    check("rd.resp", 32'(resp), 32'd0);
    check("rd.rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    for (int i = 0; i < resp_stall; i++) begin
      @(negedge clk);
      check("rd.stall_resp_valid", 32'(resp_valid), 32'd1);
      check("rd.stall_resp", 32'(resp), 32'd0);
      check("rd.stall_req_ready2", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("rd.req_ready_back", 32'(req_ready), 32'd1);
    check("rd.resp_valid_low", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_write(input logic [2:0] addr, input logic wop, input logic [2:0] waddr,
                          input logic [7:0] wdata, input logic exp_resp);
    @(negedge clk);
    check("wr.req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req = {1'b0, addr};
    @(negedge clk);
    req_valid = 1'b0;
    check("wr.wdat_ready", 32'(wdat_ready), 32'd1);
    check("wr.rdat_valid", 32'(rdat_valid), 32'd0);
    wdat_valid = 1'b1; wdat = {wop, waddr, wdata};
    @(negedge clk);
    wdat_valid = 1'b0;
    if (exp_resp == 1'b0) exp_wr = exp_wr + 8'd1;
    check("wr.resp_valid", 32'(resp_valid), 32'd1);
    check("wr.resp", 32'(resp), 32'(exp_resp));
    check("wr.wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("wr.req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req = '0;
    wdat_valid = 1'b0; wdat = '0;
    rdat_ready = 1'b0; resp_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    do_read(3'd5, 8'h00, 0, 0);
    do_write(3'd3, 1'b0, 3'd3, 8'hA5, 1'b0);
    do_read(3'd3, 8'hA5, 0, 0);

    // Rejected writes: bad opcode, then mismatched address.
    do_write(3'd3, 1'b1, 3'd3, 8'h11, 1'b1);
    do_write(3'd3, 1'b0, 3'd4, 8'h22, 1'b1);
    do_read(3'd3, 8'hA5, 0, 0);
    do_read(3'd4, 8'h00, 0, 0);

    // Write data offered while idle must be ignored.
    @(negedge clk);
    check("idle.wdat_ready", 32'(wdat_ready), 32'd0);
    wdat_valid = 1'b1; wdat = {1'b0, 3'd3, 8'hFF};
    @(negedge clk);
    wdat_valid = 1'b0;
    check("idle.wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    do_read(3'd3, 8'hA5, 0, 0);

    do_write(3'd7, 1'b0, 3'd7, 8'h7E, 1'b0);
    do_read(3'd7, 8'h7E, 5, 3);

    // Asynchronous reset while a write is waiting for its data handshake.
    @(negedge clk);
    req_valid = 1'b1; req = {1'b0, 3'd6};
    @(negedge clk);
    req_valid = 1'b0;
    check("arst.wdat_ready_pre", 32'(wdat_ready), 32'd1);
    wdat_valid = 1'b1; wdat = {1'b0, 3'd6, 8'h5A};
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    wdat_valid = 1'b0;
    rst_n = 1'b1;
    exp_wr = 8'd0; exp_rd = 8'd0;
    do_read(3'd6, 8'h00, 0, 0);
    do_read(3'd3, 8'h00, 0, 0);
    do_read(3'd7, 8'h00, 0, 0);

    // 256 accepted writes wrap wr_cnt back to zero.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      do_write(iv[2:0], 1'b0, iv[2:0], iv ^ 8'h3C, 1'b0);
    end
    check("wrap.wr_cnt", 32'(wr_cnt), 32'd0);
    for (int a = 0; a < 8; a++) begin
      logic [7:0] last;
      last = 8'(248 + a);
      do_read(3'(a), last ^ 8'h3C, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
